// File: rtl/dmem_lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : dmem_lsu_pkg                                            |
// | Brief  : Size encodings, FSM states and request checks for the   |
// |          DMem load/store unit.                                   |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
package dmem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    // Reserved size counts as bad alongside misalignment.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return (offset != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_merge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : dmem_lane_merge                                         |
// | Brief  : Big-endian byte/half lane insert (stores) and extract   |
// |          with sign/zero extension (loads).                       |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module dmem_lane_merge
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    input  logic        i_signed,
    output logic [31:0] o_merged,
    output logic [31:0] o_load_data
);

    logic [4:0]  w_shift;
    logic [31:0] w_mask;
    logic [31:0] w_lane;

    // Offset 0 is the most significant lane, so the shift counts down.
    always_comb begin
        w_shift = 5'd0;
        w_mask  = 32'hFFFF_FFFF;
        case (i_size)
            SZ_BYTE: begin
                w_shift = {~i_offset, 3'b000};
                w_mask  = 32'h0000_00FF << w_shift;
            end
            SZ_HALF: begin
                w_shift = {~i_offset[1], 4'b0000};
                w_mask  = 32'h0000_FFFF << w_shift;
            end
            default: begin
                w_shift = 5'd0;
                w_mask  = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign o_merged = (i_word & ~w_mask) | ((i_wdata << w_shift) & w_mask);
    assign w_lane   = i_word >> w_shift;

    always_comb begin
        o_load_data = i_word;
        case (i_size)
            SZ_BYTE: o_load_data = {{24{i_signed & w_lane[7]}}, w_lane[7:0]};
            SZ_HALF: o_load_data = {{16{i_signed & w_lane[15]}}, w_lane[15:0]};
            default: o_load_data = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : dmem_lsu                                                |
// | Brief  : Load/store initiator for word-wide DMem; sub-word       |
// |          stores via read-modify-write.                           |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
)
(
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Req_Valid,
    output logic                     Req_Ready,
    input  logic                     Req_Write,
    input  logic [1:0]               Req_Size,
    input  logic                     Req_Signed,
    input  logic [31:0]              Req_Addr,
    input  logic [31:0]              Req_WData,
    output logic                     Resp_Valid,
    input  logic                     Resp_Ready,
    output logic [31:0]              Resp_RData,
    output logic                     Resp_Err,
    output logic [ADDRESS_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0]    MemWriteData,
    output logic                     MemWrite,
    input  logic [DATA_WIDTH-1:0]    MemData
);

    lsu_state_t               r_state;
    lsu_state_t               w_state_nxt;
    logic                     r_write;
    logic [1:0]               r_size;
    logic                     r_signed;
    logic [1:0]               r_offset;
    logic [ADDRESS_WIDTH-1:0] r_waddr;
    logic [31:0]              r_wdata;
    logic [31:0]              r_mem;
    logic [31:0]              r_rdata;
    logic                     r_err;

    logic                     w_req_bad;
    logic                     w_accept;
    logic [31:0]              w_lane_word;
    logic [31:0]              w_merged;
    logic [31:0]              w_load_data;
    logic                     w_unused_addr;

    assign w_req_bad     = req_is_bad(Req_Size, Req_Addr[1:0]);
    assign w_accept      = (r_state == IDLE) && Req_Valid;
    assign w_unused_addr = ^Req_Addr[31:ADDRESS_WIDTH+2];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (Req_Valid) w_state_nxt = w_req_bad ? RESP : ACCESS;
            ACCESS:  w_state_nxt = (r_write && (r_size != SZ_WORD)) ? WRITE : RESP;
            WRITE:   w_state_nxt = RESP;
            RESP:    if (Resp_Ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_write  <= 1'b0;
            r_size   <= SZ_BYTE;
            r_signed <= 1'b0;
            r_offset <= 2'b00;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_mem    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_write  <= Req_Write;
            r_size   <= Req_Size;
            r_signed <= Req_Signed;
            r_offset <= Req_Addr[1:0];
            r_waddr  <= Req_Addr[ADDRESS_WIDTH+1:2];
            r_wdata  <= Req_WData;
            r_rdata  <= '0;
            r_err    <= w_req_bad;
        end else if (r_state == ACCESS) begin
            r_mem <= MemData;
            if (!r_write) begin
                r_rdata <= w_load_data;
            end
        end
    end

    // Live read data feeds the load path; the sampled word feeds the RMW merge.
    assign w_lane_word = (r_state == WRITE) ? r_mem : MemData;

    dmem_lane_merge u_lane_merge (
        .i_word      (w_lane_word),
        .i_offset    (r_offset),
        .i_size      (r_size),
        .i_wdata     (r_wdata),
        .i_signed    (r_signed),
        .o_merged    (w_merged),
        .o_load_data (w_load_data)
    );

    assign MemWrite     = (r_state == WRITE) ||
                          ((r_state == ACCESS) && r_write && (r_size == SZ_WORD));
    assign MemWriteData = !MemWrite          ? '0 :
                          (r_state == WRITE) ? w_merged : r_wdata;
    assign MemAddress   = r_waddr;

    assign Req_Ready  = (r_state == IDLE);
    assign Resp_Valid = (r_state == RESP);
    assign Resp_RData = r_rdata;
    assign Resp_Err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_dmem_lsu                                             |
// | Brief  : Self-checking bench for dmem_lsu with a behavioural     |
// |          DMem and a scoreboard-driven reference memory.          |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module tb_dmem_lsu;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_signed = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic          mem_write;
    logic [31:0]   mem_data;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
        logic [7:0]  waddr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] dmem [0:255];
    logic [31:0] ref_mem [0:255];

    always #5 clk = ~clk;

    assign mem_data = dmem[mem_address];
    always @(posedge clk) if (mem_write) dmem[mem_address] <= mem_write_data;

    dmem_lsu #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .Clk          (clk),
        .Rst_n        (rst_n),
        .Req_Valid    (req_valid),
        .Req_Ready    (req_ready),
        .Req_Write    (req_write),
        .Req_Size     (req_size),
        .Req_Signed   (req_signed),
        .Req_Addr     (req_addr),
        .Req_WData    (req_wdata),
        .Resp_Valid   (resp_valid),
        .Resp_Ready   (resp_ready),
        .Resp_RData   (resp_rdata),
        .Resp_Err     (resp_err),
        .MemAddress   (mem_address),
        .MemWriteData (mem_write_data),
        .MemWrite     (mem_write),
        .MemData      (mem_data)
    );

    // Reference behaviour: big-endian lanes, written lane by lane.
    task automatic predict(input logic wr, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] w;
        logic [7:0]  wa;
        logic [7:0]  b;
        logic [15:0] h;
        wa      = a[9:2];
        w       = ref_mem[wa];
        e.rdata = 32'h0;
        e.nwr   = 0;
        e.waddr = wa;
        e.err   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        if (e.err) begin
            e.lat = 1;
        end else if (wr) begin
            e.nwr = 1;
            if (sz == 2'b10) begin
                e.lat = 2;
                w     = wd;
            end else begin
                e.lat = 3;
                if (sz == 2'b00) begin
                    case (a[1:0])
                        2'd0: w[31:24] = wd[7:0];
                        2'd1: w[23:16] = wd[7:0];
                        2'd2: w[15:8]  = wd[7:0];
                        default: w[7:0] = wd[7:0];
                    endcase
                end else if (a[1]) begin
                    w[15:0] = wd[15:0];
                end else begin
                    w[31:16] = wd[15:0];
                end
            end
            ref_mem[wa] = w;
        end else begin
            e.lat = 2;
            case (sz)
                2'b00: begin
                    case (a[1:0])
                        2'd0: b = w[31:24];
                        2'd1: b = w[23:16];
                        2'd2: b = w[15:8];
                        default: b = w[7:0];
                    endcase
                    e.rdata = sgn ? {{24{b[7]}}, b} : {24'h0, b};
                end
                2'b01: begin
                    h = a[1] ? w[15:0] : w[31:16];
                    e.rdata = sgn ? {{16{h[15]}}, h} : {16'h0, h};
                end
                default: e.rdata = w;
            endcase
        end
        sb.push_back(e);
    endtask

    // One request; 'hold' cycles of response backpressure with a competing request driven.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] a, input logic [31:0] wd, input int hold);
        exp_t        e;
        int          cyc;
        int          nwr;
        logic [7:0]  wa_seen;
        logic [31:0] rd0;
        logic        err0;
        predict(wr, sz, sgn, a, wd);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        cyc = 1;
        nwr = 0;
        wa_seen = '0;
        while (resp_valid !== 1'b1 && cyc < 20) begin
            if (mem_write === 1'b1) begin
                nwr++;
                wa_seen = mem_address;
            end else begin
                n_cmp++;
                if (mem_write_data !== 32'h0) begin
                    n_bad++;
                    $display("FAIL wdata_idle_zero: got %h want 00000000", mem_write_data);
                end
            end
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        n_cmp++;
        if (cyc !== e.lat) begin
            n_bad++;
            $display("FAIL latency a=%h: got %0d want %0d", a, cyc, e.lat);
        end
        n_cmp++;
        if (resp_rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL rdata a=%h: got %h want %h", a, resp_rdata, e.rdata);
        end
        n_cmp++;
        if (resp_err !== e.err) begin
            n_bad++;
            $display("FAIL err a=%h: got %b want %b", a, resp_err, e.err);
        end
        n_cmp++;
        if (nwr !== e.nwr) begin
            n_bad++;
            $display("FAIL memwrite_count a=%h: got %0d want %0d", a, nwr, e.nwr);
        end
        if (e.nwr > 0) begin
            n_cmp++;
            if (wa_seen !== e.waddr) begin
                n_bad++;
                $display("FAIL memwrite_addr a=%h: got %h want %h", a, wa_seen, e.waddr);
            end
        end
        rd0  = resp_rdata;
        err0 = resp_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_size  = 2'b10;
            req_addr  = 32'h0000_03F0;
            req_wdata = 32'hBAD0_BAD0;
            @(negedge clk);
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_rdata !== rd0 || resp_err !== err0 ||
                req_ready !== 1'b0 || mem_write !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_stable: got v=%b d=%h e=%b rdy=%b mw=%b want v=1 d=%h e=%b rdy=0 mw=0",
                         resp_valid, resp_rdata, resp_err, req_ready, mem_write, rd0, err0);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL handshake_idle: got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset;
        #12;
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 ||
            mem_write !== 1'b0 || mem_address !== '0 || mem_write_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%h e=%b mw=%b ma=%h wd=%h want 1 0 0 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err, mem_write, mem_address, mem_write_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word;
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 0);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0410, 32'h0, 0);
    endtask

    task automatic test_subword_store;
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1122_3344, 0);
        run_req(1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'hFFFF_FFAA, 0);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 0);
        run_req(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_5A6B, 0);
        run_req(1'b1, 2'b00, 1'b0, 32'h0000_0023, 32'h0000_00C3, 0);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 0);
    endtask

    task automatic test_load_extend;
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h80FF_7F01, 0);
        run_req(1'b0, 2'b00, 1'b1, 32'h0000_0000, 32'h0, 0);
        run_req(1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0, 0);
        run_req(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 0);
        run_req(1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 0);
        run_req(1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0, 0);
        run_req(1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0, 0);
        run_req(1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0, 0);
    endtask

    task automatic test_errors;
        run_req(1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_CAFE, 0);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 0);
        run_req(1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h1234_5678, 0);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 0);
    endtask

    task automatic test_backpressure;
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_03F0, 32'h1234_5678, 0);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 5);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_03F0, 32'h0, 0);
    endtask

    task automatic test_reset_mid_rmw;
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'h5566_7788, 0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0000_0031;
        req_wdata  = 32'h0000_0099;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        n_cmp++;
        if (mem_write !== 1'b1) begin
            n_bad++;
            $display("FAIL rmw_write_phase: got %b want 1", mem_write);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_write !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: got mw=%b rdy=%b v=%b want 0 1 0", mem_write, req_ready, resp_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: got %b want 1", req_ready);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        test_reset();
        test_word();
        test_subword_store();
        test_load_extend();
        test_errors();
        test_backpressure();
        test_reset_mid_rmw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
